// File: rtl/conv2_mac3x3.sv
// conv2_mac3x3: second-layer 3x3 convolution engine. Pulls windows from the conv1
// buffer, multiply-accumulates against kernel + bias, applies ReLU and saturation.
module conv2_mac3x3 #(
  parameter int DATA_W  = 16,
  parameter int IN_W    = 111,
  parameter int OUT_DIM = 109
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  wt_valid,
  input  logic [DATA_W-1:0]     wt_data,
  input  logic                  start,
  input  logic                  buf_empty,
  output logic                  buf_rd_en,
  input  logic [9*DATA_W-1:0]   win_data,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int FRAC     = DATA_W / 2;
  localparam int PROD_W   = 2 * DATA_W;
  localparam int SUM_W    = PROD_W + 4;
  localparam int RES_W    = SUM_W - FRAC;
  localparam int RD_TOTAL = OUT_DIM * IN_W;
  localparam int RD_W     = $clog2(RD_TOTAL + 1);
  localparam int COL_W    = $clog2(IN_W);
  localparam logic [RD_W-1:0]   RD_END   = RD_W'(RD_TOTAL);
  localparam logic [RD_W-1:0]   RD_LAST  = RD_W'(RD_TOTAL - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IN_W - 1);
  localparam logic [COL_W-1:0]  COL_KEEP = COL_W'(OUT_DIM);
  localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                    state_r, state_nxt_s;
  logic [DATA_W-1:0]         wt_r [0:9];
  logic [3:0]                wt_cnt_r;
  logic                      kernel_loaded_r;
  logic [RD_W-1:0]           rd_cnt_r;
  logic [COL_W-1:0]          col_r;
  logic                      rd_en_s, done_s, start_ok_s, last_rd_s, pipe_empty_s, wt_wr_s;
  logic                      v0_r, v1_r, v2_r, k0_r, k1_r, k2_r;
  logic signed [PROD_W-1:0]  prod_r [0:8];
  logic signed [SUM_W-1:0]   sum_s, sum_r;
  logic [RES_W-1:0]          res_s;
  logic [DATA_W-1:0]         sat_s, dout_r;
  logic                      dout_valid_r, busy_r, frame_done_r;

  assign start_ok_s   = (state_r == IDLE) && start && kernel_loaded_r && (wt_cnt_r == 4'd0);
  assign wt_wr_s      = (state_r == IDLE) && wt_valid && !start_ok_s;
  assign last_rd_s    = rd_en_s && (rd_cnt_r == RD_LAST);
  assign pipe_empty_s = !v0_r && !v1_r && !v2_r;

  always_ff @(posedge clk) begin
    if (!rst_a) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start_ok_s)   state_nxt_s = RUN;   else state_nxt_s = IDLE;
      RUN:     if (last_rd_s)    state_nxt_s = DRAIN; else state_nxt_s = RUN;
      DRAIN:   if (pipe_empty_s) state_nxt_s = IDLE;  else state_nxt_s = DRAIN;
      default: state_nxt_s = IDLE;
    endcase
  end

  always_comb begin
    rd_en_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      RUN:     rd_en_s = !buf_empty && (rd_cnt_r < RD_END);
      DRAIN:   done_s  = pipe_empty_s;
      default: begin
        rd_en_s = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Kernel store: slots 0..8 are weights, slot 9 is bias; any partial load invalidates it.
  always_ff @(posedge clk) begin
    if (!rst_a) begin
      for (int i = 0; i < 10; i++) wt_r[i] <= '0;
      wt_cnt_r        <= 4'd0;
      kernel_loaded_r <= 1'b0;
    end else if (wt_wr_s) begin
      wt_r[wt_cnt_r] <= wt_data;
      if (wt_cnt_r == 4'd9) begin
        wt_cnt_r        <= 4'd0;
        kernel_loaded_r <= 1'b1;
      end else begin
        wt_cnt_r        <= wt_cnt_r + 4'd1;
        kernel_loaded_r <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      rd_cnt_r <= '0;
      col_r    <= '0;
    end else if (start_ok_s) begin
      rd_cnt_r <= '0;
      col_r    <= '0;
    end else if (rd_en_s) begin
      rd_cnt_r <= rd_cnt_r + {{(RD_W-1){1'b0}}, 1'b1};
      col_r    <= (col_r == COL_LAST) ? '0 : col_r + {{(COL_W-1){1'b0}}, 1'b1};
    end
  end

  // Valid and keep tags ride alongside the data stages; wrapped columns never reach dout.
  always_ff @(posedge clk) begin
    if (!rst_a) begin
      {v0_r, v1_r, v2_r} <= 3'b000;
      {k0_r, k1_r, k2_r} <= 3'b000;
    end else begin
      v0_r <= rd_en_s;
      k0_r <= (col_r < COL_KEEP);
      v1_r <= v0_r;
      k1_r <= k0_r;
      v2_r <= v1_r;
      k2_r <= k1_r;
    end
  end

  // win_data arrives the cycle after the strobe and is multiplied straight away.
  always_ff @(posedge clk) begin
    if (!rst_a) begin
      for (int i = 0; i < 9; i++) prod_r[i] <= '0;
    end else if (v0_r) begin
      for (int i = 0; i < 9; i++)
        prod_r[i] <= PROD_W'($signed(win_data[(8-i)*DATA_W +: DATA_W]))
                   * PROD_W'($signed(wt_r[i]));
    end
  end

  always_comb begin
    sum_s = SUM_W'($signed(wt_r[9])) <<< FRAC;
    for (int i = 0; i < 9; i++) sum_s = sum_s + SUM_W'(prod_r[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_a)    sum_r <= '0;
    else if (v1_r) sum_r <= sum_s;
  end

  assign res_s = RES_W'(sum_r >>> FRAC);

  // ReLU then clamp to the largest positive Q8.8 value.
  always_comb begin
    if (res_s[RES_W-1])                 sat_s = '0;
    else if (|res_s[RES_W-2:DATA_W-1])  sat_s = SAT_MAX;
    else                                sat_s = res_s[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      dout_valid_r <= v2_r && k2_r;
      if (v2_r && k2_r) dout_r <= sat_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      busy_r       <= (state_nxt_s != IDLE);
      frame_done_r <= done_s;
    end
  end

  assign buf_rd_en  = rd_en_s;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: doc/conv2_mac3x3.md
# conv2_mac3x3

Second-layer 3x3 convolution engine sitting directly downstream of the conv1 window buffer. Pulls 9-pixel windows from the buffer with a read strobe and multiply-accumulates each window against a loaded 3x3 kernel plus bias. Applies ReLU and saturation, then emits one 16-bit conv2 pixel per valid window. Windows that wrap past the right edge of a row are discarded, so exactly OUT_DIM x OUT_DIM pixels are produced per frame.

## Interface
- DATA_W, 16: pixel/weight width, signed Q8.8
- IN_W, 111: windows per row issued by the upstream buffer (row stride)
- OUT_DIM, 109: valid output columns and rows per frame
- clk  in  1  clock, all logic on rising edge
- rst_a  in  1  synchronous, active-low reset
- wt_valid  in  1  weight/bias word strobe (accepted only in IDLE)
- wt_data  in  DATA_W  words in order w0..w8, then bias
- start  in  1  start one frame (ignored unless IDLE and kernel loaded)
- buf_empty  in  1  upstream buffer empty
- buf_rd_en  out  1  read strobe to upstream buffer
- win_data  in  9*DATA_W  window, [143:128]=p0 (top-left) ... [15:0]=p8 (bottom-right), valid the cycle after buf_rd_en
- dout  out  DATA_W  conv2 output pixel, Q8.8, >= 0
- dout_valid  out  1  dout qualifier, one-cycle pulse per pixel
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle pulse after last pixel of frame

## Operation
- States: IDLE, RUN, DRAIN. Reset -> IDLE.
- IDLE: each wt_valid writes wt_data to slot wt_cnt (0..8 weights, 9 bias), wt_cnt increments. At wt_cnt==9 write: wt_cnt->0, kernel_loaded->1. Partial load (wt_cnt!=0) clears kernel_loaded. Weights persist across frames.
- IDLE->RUN on start && kernel_loaded && wt_cnt==0; clears col/row/read counters.
- RUN: buf_rd_en = !buf_empty && rd_cnt < OUT_DIM*IN_W. rd_cnt counts issued reads. Last read issued -> DRAIN.
- Each read carries a tag keep = (col < OUT_DIM); col counts 0..IN_W-1 per read, wraps to 0 and row increments. Tag travels with the pipeline; keep==0 windows never assert dout_valid.
- DRAIN: no reads; wait until pipeline empty, then pulse frame_done and return to IDLE. start and wt_valid ignored outside IDLE.
- Arithmetic: products p_i*w_i signed 32-bit Q16.16. Sum of 9 products plus (bias sign-extended, <<8) in 36-bit signed. Result = sum >>> 8 (truncate toward -inf). ReLU: negative -> 0. Saturate: > 0x7FFF -> 0x7FFF. dout = low 16 bits.

## Timing
- Reset (rst_a low at a clock edge): state IDLE, wt_cnt 0, kernel_loaded 0, all weights/bias 0, counters 0, pipeline valids 0. buf_rd_en, dout, dout_valid, busy and frame_done all 0. Reset mid-frame aborts the frame with no frame_done.
- Read strobe at cycle t -> win_data sampled at t+1 -> products registered t+2 -> adder-tree sum registered t+3 -> dout/dout_valid registered at t+4. Fixed latency 4, fully pipelined, one window per cycle sustained.
- buf_empty deasserting stalls read issue only; in-flight windows continue (no back-pressure downstream).
- dout holds its last value when dout_valid is 0.
- frame_done is asserted the cycle after the final kept pixel's dout_valid, provided the final read was a keep. Otherwise it is asserted the cycle after the pipeline drains.
- busy falls in the same cycle frame_done is high.

## Test plan
- Reset with wt_valid and start high -> all outputs 0, no buf_rd_en, state IDLE; then load 10 words -> kernel_loaded, start accepted.
- Kernel all 0x0100 (1.0), bias 0; window all 0x0100 -> dout 0x0900, dout_valid exactly 4 cycles after buf_rd_en.
- Kernel w4=0x0100 only, bias 0xFF00 (-1.0), centre pixel 0x0080 -> sum negative -> dout 0x0000; centre pixel 0x0300 -> dout 0x0200.
- Kernel all 0x7FFF, window all 0x7FFF -> dout saturates to 0x7FFF.
- Full frame, buf_empty toggled randomly -> exactly 12099 reads, exactly 11881 dout_valid pulses, none for col 109/110 of any row, single frame_done, back to IDLE.
- rst_a low mid-frame -> next cycle buf_rd_en/dout_valid 0, no frame_done, kernel cleared (start then ignored until reload).
